posit_mac_seq: RTL and testbench
================================

POSIT_MAC_SEQ -- requirements
Module: posit_mac_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, posit bit width (matches MAC).
REQ-002 SHALL have parameter K, default 9, dot-product length (matches MAC).
REQ-003 SHALL have parameter AW, default 10, memory address width.
REQ-004 SHALL have parameter NW, default 8, output-count width.
REQ-005 SHALL have parameter TMO, default 64, MAC result timeout in cycles.
REQ-006 SHALL have port clk_i, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have ports cmd_vld_i, input, 1, and cmd_rdy_o, output, 1: the command handshake.
REQ-009 SHALL have ports cmd_waddr_i and cmd_daddr_i, input, AW each: weight and data base addresses.
REQ-010 SHALL have port cmd_nout_i, input, NW: number of dot products to run.
REQ-011 SHALL have ports mem_re_o, output, 1, and w_addr_o, d_addr_o, output, AW each: memory read request.
REQ-012 SHALL have ports w_rdata_i and d_rdata_i, input, WIDTH each: read data, valid exactly 1 cycle after mem_re_o.
REQ-013 SHALL have ports mac_vld_o, output, 1, and mac_win_o, mac_din_o, output, WIDTH each: driving the MAC.
REQ-014 SHALL have ports mac_acc_i, input, WIDTH, and mac_vld_i, input, 1: the MAC result and its 1-cycle valid pulse.
REQ-015 SHALL have ports res_vld_o, output, 1, res_data_o, output, WIDTH, and res_rdy_i, input, 1: the result stream.
REQ-016 SHALL have ports busy_o, done_o and err_o, output, 1 each.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, DRAIN, OUT.
REQ-018 cmd_rdy_o SHALL be 1 only in IDLE; a command is accepted when cmd_vld_i and cmd_rdy_o are both 1 on a clock edge.
REQ-019 On accept: latch waddr, daddr and nout; clear err_o and the output index j. If nout = 0, go to IDLE and pulse done_o; otherwise go to FETCH.
REQ-020 FETCH SHALL last exactly K cycles with mem_re_o = 1 and, on cycle i (0..K-1), w_addr_o = waddr + j*K + i and d_addr_o = daddr + i, both modulo 2^AW.
REQ-021 mac_vld_o SHALL be mem_re_o delayed one register stage, so it is high for exactly K consecutive cycles per dot product.
REQ-022 mac_win_o and mac_din_o SHALL be w_rdata_i and d_rdata_i, passed combinationally.
REQ-023 After FETCH the FSM SHALL enter DRAIN, with mem_re_o = 0 and a cycle counter cleared.
REQ-024 In DRAIN, mac_vld_i = 1 SHALL capture mac_acc_i into res_data_o and move to OUT.
REQ-025 In DRAIN, if the counter reaches TMO-1 with no mac_vld_i, the FSM SHALL set err_o (sticky), pulse done_o and go to IDLE.
REQ-026 A mac_vld_i arriving outside DRAIN SHALL be ignored.
REQ-027 In OUT, res_vld_o = 1 SHALL hold, with res_data_o stable, until res_rdy_i = 1.
REQ-028 On the OUT handshake: if j = nout-1, go to IDLE and pulse done_o for 1 cycle; otherwise increment j and go to FETCH.
REQ-029 mac_vld_o SHALL be low for at least 1 cycle between consecutive dot products, so the MAC's valid-history pipeline clears; DRAIN/OUT guarantee this.
REQ-030 busy_o SHALL be 1 in any state other than IDLE.
REQ-031 Results SHALL be emitted in index order j = 0..nout-1; there is no result buffering beyond one register, and backpressure stalls the next FETCH.
REQ-032 A command presented while busy SHALL NOT be accepted; it stays pending on cmd_vld_i.

Reset
REQ-033 rstn low SHALL force IDLE and set every output and internal register to 0 (except cmd_rdy_o, which is 1 once in IDLE). This holds mid-operation, including mid-FETCH and mid-OUT.
REQ-034 After reset release the block SHALL accept a new command with no recovery cycles.

Verification (MAC stub returns a programmed value 14 cycles after mac_vld_o falls)
REQ-035 Single job: K=9, nout=1, waddr=0x000, daddr=0x100, stub returns 0x59, res_rdy_i=1 -> addresses 0x000..0x008 and 0x100..0x108, mac_vld_o high for 9 cycles, one res 0x59, done_o pulse.
REQ-036 Multi job: nout=3, res_rdy_i=1 -> weight bases 0x000, 0x009 and 0x012, data addresses repeat from 0x100, 3 results in order, 1 done_o pulse.
REQ-037 Backpressure: res_rdy_i=0 for 20 cycles on result 0 -> res_vld_o and res_data_o held, no mem_re_o, and the second FETCH starts the cycle after the handshake.
REQ-038 Timeout: stub never responds -> err_o=1 and done_o pulse 64 cycles after DRAIN entry, return to IDLE; the next accepted command clears err_o.
REQ-039 Edges: nout=0 -> done_o one cycle after accept, no mem_re_o; waddr=0x3FC -> addresses wrap to 0x000..0x004.
REQ-040 Reset: rstn low on FETCH cycle 4 -> all outputs 0 next cycle; the next command runs cleanly from j=0.

Source files
------------

// File: rtl/posit_mac_seq.sv
// Sequencer for a posit MAC: fetches K weight/data pairs per dot product,
// waits for the MAC result, and streams nout results out with backpressure.
module posit_mac_seq #(
    parameter int WIDTH = 8,
    parameter int K     = 9,
    parameter int AW    = 10,
    parameter int NW    = 8,
    parameter int TMO   = 64
) (
    input  logic             clk_i,
    input  logic             rstn,
    input  logic             cmd_vld_i,
    output logic             cmd_rdy_o,
    input  logic [AW-1:0]    cmd_waddr_i,
    input  logic [AW-1:0]    cmd_daddr_i,
    input  logic [NW-1:0]    cmd_nout_i,
    output logic             mem_re_o,
    output logic [AW-1:0]    w_addr_o,
    output logic [AW-1:0]    d_addr_o,
    input  logic [WIDTH-1:0] w_rdata_i,
    input  logic [WIDTH-1:0] d_rdata_i,
    output logic             mac_vld_o,
    output logic [WIDTH-1:0] mac_win_o,
    output logic [WIDTH-1:0] mac_din_o,
    input  logic [WIDTH-1:0] mac_acc_i,
    input  logic             mac_vld_i,
    output logic             res_vld_o,
    output logic [WIDTH-1:0] res_data_o,
    input  logic             res_rdy_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_OUT} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_wbase;
    logic [AW-1:0] r_daddr;
    logic [NW-1:0] r_nout;
    logic [NW-1:0] r_j;
    logic [IW-1:0] r_i;
    logic [TW-1:0] r_cnt;
    logic          r_mac_vld;
    logic [WIDTH-1:0] r_res_data;
    logic          r_err;
    logic          r_done;

    logic w_accept;
    logic w_fetch_last;
    logic w_tmo;
    logic w_last_job;

    assign cmd_rdy_o    = (r_state == S_IDLE);
    assign busy_o       = (r_state != S_IDLE);
    assign mem_re_o     = (r_state == S_FETCH);
    assign res_vld_o    = (r_state == S_OUT);
    assign w_accept     = cmd_vld_i && cmd_rdy_o;
    assign w_fetch_last = (r_i == IW'(K - 1));
    assign w_tmo        = (r_cnt == TW'(TMO - 1));
    assign w_last_job   = (r_j == r_nout - NW'(1));

    // Weight base advances by K per dot product, so no multiplier is needed.
    assign w_addr_o   = mem_re_o ? r_wbase + AW'(r_i) : '0;
    assign d_addr_o   = mem_re_o ? r_daddr + AW'(r_i) : '0;
    assign mac_vld_o  = r_mac_vld;
    assign mac_win_o  = w_rdata_i;
    assign mac_din_o  = d_rdata_i;
    assign res_data_o = r_res_data;
    assign done_o     = r_done;
    assign err_o      = r_err;

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (cmd_nout_i == '0) ? S_IDLE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_fetch_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mac_vld_i) begin
                    w_next = S_OUT;
                end else if (w_tmo) begin
                    w_next = S_IDLE;
                end
            end
            S_OUT: begin
                if (res_rdy_i) begin
                    w_next = w_last_job ? S_IDLE : S_FETCH;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            r_wbase    <= '0;
            r_daddr    <= '0;
            r_nout     <= '0;
            r_j        <= '0;
            r_i        <= '0;
            r_cnt      <= '0;
            r_mac_vld  <= 1'b0;
            r_res_data <= '0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_mac_vld <= mem_re_o;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_wbase <= cmd_waddr_i;
                        r_daddr <= cmd_daddr_i;
                        r_nout  <= cmd_nout_i;
                        r_j     <= '0;
                        r_i     <= '0;
                        r_err   <= 1'b0;
                        r_done  <= (cmd_nout_i == '0);
                    end
                end
                S_FETCH: begin
                    if (w_fetch_last) begin
                        r_i   <= '0;
                        r_cnt <= '0;
                    end else begin
                        r_i <= r_i + IW'(1);
                    end
                end
                S_DRAIN: begin
                    // A result arriving on the timeout cycle still wins.
                    if (mac_vld_i) begin
                        r_res_data <= mac_acc_i;
                    end else if (w_tmo) begin
                        r_err  <= 1'b1;
                        r_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                S_OUT: begin
                    if (res_rdy_i) begin
                        if (w_last_job) begin
                            r_done <= 1'b1;
                        end else begin
                            r_j     <= r_j + NW'(1);
                            r_wbase <= r_wbase + AW'(K);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_posit_mac_seq.sv
// Scoreboard bench for posit_mac_seq: directed jobs with a memory model and a
// MAC stub that answers 14 cycles after mac_vld_o falls.
module tb_posit_mac_seq;

    localparam int WIDTH = 8;
    localparam int K     = 9;
    localparam int AW    = 10;
    localparam int NW    = 8;
    localparam int TMO   = 64;

    logic             clk;
    logic             rstn;
    logic             cmd_vld_i;
    logic             cmd_rdy_o;
    logic [AW-1:0]    cmd_waddr_i;
    logic [AW-1:0]    cmd_daddr_i;
    logic [NW-1:0]    cmd_nout_i;
    logic             mem_re_o;
    logic [AW-1:0]    w_addr_o;
    logic [AW-1:0]    d_addr_o;
    logic [WIDTH-1:0] w_rdata_i;
    logic [WIDTH-1:0] d_rdata_i;
    logic             mac_vld_o;
    logic [WIDTH-1:0] mac_win_o;
    logic [WIDTH-1:0] mac_din_o;
    logic [WIDTH-1:0] mac_acc_i;
    logic             mac_vld_i;
    logic             res_vld_o;
    logic [WIDTH-1:0] res_data_o;
    logic             res_rdy_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    posit_mac_seq #(.WIDTH(WIDTH), .K(K), .AW(AW), .NW(NW), .TMO(TMO)) dut (
        .clk_i(clk), .rstn(rstn),
        .cmd_vld_i(cmd_vld_i), .cmd_rdy_o(cmd_rdy_o),
        .cmd_waddr_i(cmd_waddr_i), .cmd_daddr_i(cmd_daddr_i), .cmd_nout_i(cmd_nout_i),
        .mem_re_o(mem_re_o), .w_addr_o(w_addr_o), .d_addr_o(d_addr_o),
        .w_rdata_i(w_rdata_i), .d_rdata_i(d_rdata_i),
        .mac_vld_o(mac_vld_o), .mac_win_o(mac_win_o), .mac_din_o(mac_din_o),
        .mac_acc_i(mac_acc_i), .mac_vld_i(mac_vld_i),
        .res_vld_o(res_vld_o), .res_data_o(res_data_o), .res_rdy_i(res_rdy_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    typedef struct packed {
        logic [AW-1:0] w;
        logic [AW-1:0] d;
    } addr_t;

    addr_t            aq[$];
    logic [WIDTH-1:0] rq[$];
    logic [WIDTH-1:0] sq[$];

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    bit stub_en = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] wmem(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    function automatic logic [WIDTH-1:0] dmem(input logic [AW-1:0] a);
        return a[7:0] + 8'h3C;
    endfunction

    // Synchronous read memories: data one cycle after the request.
    always @(posedge clk) begin
        w_rdata_i <= mem_re_o ? wmem(w_addr_o) : '0;
        d_rdata_i <= mem_re_o ? dmem(d_addr_o) : '0;
    end

    // MAC stub
    initial begin
        int  scnt;
        bit  prev_mv;
        scnt = 0;
        prev_mv = 1'b0;
        mac_vld_i = 1'b0;
        mac_acc_i = '0;
        forever begin
            @(negedge clk);
            mac_vld_i = 1'b0;
            if (!rstn) begin
                scnt = 0;
            end else begin
                if (scnt == 1) begin
                    mac_vld_i = 1'b1;
                    mac_acc_i = (sq.size() != 0) ? sq.pop_front() : 8'hEE;
                end
                if (scnt > 0) scnt--;
                if (prev_mv && !mac_vld_o && stub_en) scnt = 14;
            end
            prev_mv = mac_vld_o;
        end
    end

    // Monitor: addresses, MAC drive, results, done pulses
    initial begin
        int            run;
        bit            last_re;
        logic [AW-1:0] last_w;
        logic [AW-1:0] last_d;
        addr_t         e;
        logic [WIDTH-1:0] r;
        run = 0;
        last_re = 1'b0;
        last_w = '0;
        last_d = '0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (mem_re_o) begin
                    if (aq.size() == 0) begin
                        check("unexpected_mem_re", 32'd1, 32'd0);
                    end else begin
                        e = aq.pop_front();
                        check("w_addr", 32'(w_addr_o), 32'(e.w));
                        check("d_addr", 32'(d_addr_o), 32'(e.d));
                    end
                end
                if (mac_vld_o) begin
                    check("mac_vld_follows_re", 32'(last_re), 32'd1);
                    check("mac_win", 32'(mac_win_o), 32'(wmem(last_w)));
                    check("mac_din", 32'(mac_din_o), 32'(dmem(last_d)));
                    run++;
                end else if (run != 0) begin
                    check("mac_vld_len", 32'(run), 32'(K));
                    run = 0;
                end
                if (res_vld_o && res_rdy_i) begin
                    if (rq.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        r = rq.pop_front();
                        check("res_data", 32'(res_data_o), 32'(r));
                    end
                end
                if (busy_o && cmd_rdy_o) check("rdy_while_busy", 32'd1, 32'd0);
                if (done_o) done_cnt++;
                last_re = mem_re_o;
                last_w = w_addr_o;
                last_d = d_addr_o;
            end else begin
                run = 0;
                last_re = 1'b0;
            end
        end
    end

    task automatic job(input logic [AW-1:0] wa, input logic [AW-1:0] da,
                       input logic [NW-1:0] n, input logic [WIDTH-1:0] v, input bit with_res);
        addr_t e;
        int    t;
        for (int j = 0; j < int'(n); j++) begin
            for (int i = 0; i < K; i++) begin
                e.w = AW'(int'(wa) + j * K + i);
                e.d = AW'(int'(da) + i);
                aq.push_back(e);
            end
            if (with_res) begin
                sq.push_back(v + WIDTH'(j));
                rq.push_back(v + WIDTH'(j));
            end
        end
        @(posedge clk);
        #1;
        cmd_waddr_i = wa;
        cmd_daddr_i = da;
        cmd_nout_i  = n;
        cmd_vld_i   = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (cmd_rdy_o) break;
            t++;
            if (t > 2000) begin
                check("cmd_accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        cmd_vld_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            if (done_o) break;
            t++;
            if (t > 3000) begin
                check(name, 32'd0, 32'd1);
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_rdy"}, 32'(cmd_rdy_o), 32'd1);
        check({tag, "_mem_re"},  32'(mem_re_o), 32'd0);
        check({tag, "_w_addr"},  32'(w_addr_o), 32'd0);
        check({tag, "_d_addr"},  32'(d_addr_o), 32'd0);
        check({tag, "_mac_vld"}, 32'(mac_vld_o), 32'd0);
        check({tag, "_res_vld"}, 32'(res_vld_o), 32'd0);
        check({tag, "_res_data"}, 32'(res_data_o), 32'd0);
        check({tag, "_busy"},    32'(busy_o), 32'd0);
        check({tag, "_done"},    32'(done_o), 32'd0);
        check({tag, "_err"},     32'(err_o), 32'd0);
    endtask

    initial begin
        int d0;
        int t;
        int n;
        rstn = 1'b0;
        cmd_vld_i = 1'b0;
        cmd_waddr_i = '0;
        cmd_daddr_i = '0;
        cmd_nout_i = '0;
        res_rdy_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1 rstn = 1'b1;

        // Single job
        d0 = done_cnt;
        job(10'h000, 10'h100, 8'd1, 8'h59, 1'b1);
        wait_done("single_done_timeout");
        check("single_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("single_addr_left", 32'(aq.size()), 32'd0);
        check("single_res_left", 32'(rq.size()), 32'd0);

        // Multi job
        d0 = done_cnt;
        job(10'h000, 10'h100, 8'd3, 8'h21, 1'b1);
        wait_done("multi_done_timeout");
        check("multi_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("multi_addr_left", 32'(aq.size()), 32'd0);
        check("multi_res_left", 32'(rq.size()), 32'd0);

        // Backpressure on result 0
        res_rdy_i = 1'b0;
        job(10'h040, 10'h200, 8'd2, 8'h30, 1'b1);
        t = 0;
        while (!res_vld_o && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("bp_res_vld_seen", 32'(res_vld_o), 32'd1);
        for (int c = 0; c < 20; c++) begin
            check("bp_res_vld_held", 32'(res_vld_o), 32'd1);
            check("bp_res_data_held", 32'(res_data_o), 32'h30);
            check("bp_no_mem_re", 32'(mem_re_o), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 res_rdy_i = 1'b1;
        @(negedge clk);
        check("bp_before_hs_mem_re", 32'(mem_re_o), 32'd0);
        @(negedge clk);
        check("bp_fetch_after_hs", 32'(mem_re_o), 32'd1);
        check("bp_fetch_waddr", 32'(w_addr_o), 32'h049);
        wait_done("bp_done_timeout");
        check("bp_res_left", 32'(rq.size()), 32'd0);

        // Timeout: stub silent
        stub_en = 1'b0;
        d0 = done_cnt;
        job(10'h000, 10'h100, 8'd1, 8'h00, 1'b0);
        t = 0;
        while (!mem_re_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        while (mem_re_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        n = 0;
        while (!done_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tmo_latency", 32'(n), 32'(TMO));
        check("tmo_err_set", 32'(err_o), 32'd1);
        check("tmo_back_idle", 32'(busy_o), 32'd0);
        @(negedge clk);
        check("tmo_err_sticky", 32'(err_o), 32'd1);
        check("tmo_done_pulses", 32'(done_cnt - d0), 32'd1);
        stub_en = 1'b1;
        job(10'h010, 10'h100, 8'd1, 8'h77, 1'b1);
        @(negedge clk);
        check("tmo_err_cleared", 32'(err_o), 32'd0);
        wait_done("tmo_next_done_timeout");

        // nout = 0
        d0 = done_cnt;
        job(10'h000, 10'h000, 8'd0, 8'h00, 1'b0);
        @(negedge clk);
        check("nout0_done", 32'(done_o), 32'd1);
        check("nout0_no_mem_re", 32'(mem_re_o), 32'd0);
        @(negedge clk);
        check("nout0_idle", 32'(busy_o), 32'd0);
        check("nout0_done_pulses", 32'(done_cnt - d0), 32'd1);

        // Address wrap
        job(10'h3FC, 10'h3FE, 8'd1, 8'h5A, 1'b1);
        wait_done("wrap_done_timeout");
        check("wrap_addr_left", 32'(aq.size()), 32'd0);
        check("wrap_res_left", 32'(rq.size()), 32'd0);

        // Reset during FETCH cycle 4
        job(10'h080, 10'h100, 8'd2, 8'h11, 1'b1);
        repeat (4) @(posedge clk);
        #1 rstn = 1'b0;
        check("rst_addr_popped", 32'(aq.size()), 32'(2 * K - 4));
        @(negedge clk);
        check_idle_outputs("midrst");
        aq.delete();
        rq.delete();
        sq.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
        d0 = done_cnt;
        job(10'h020, 10'h040, 8'd1, 8'h66, 1'b1);
        wait_done("rst_next_done_timeout");
        check("rst_next_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("rst_next_addr_left", 32'(aq.size()), 32'd0);
        check("rst_next_res_left", 32'(rq.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
